spline_out_buf: RTL and testbench

//  Output elastic buffer directly downstream of the C-MOMS spline interpolator. Captures each new 9-bit

---
 rtl/outbuf_pkg.sv | 19 +
 rtl/outbuf_mem.sv | 32 +++
 rtl/spline_out_buf.sv | 145 ++++++++++++++
 tb/tb_spline_out_buf.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/outbuf_pkg.sv
// outbuf_pkg: types and helpers shared by the spline output buffer.
//   SAMPLE_W     : width of the interpolated sample (signed)
//   sample_t     : signed sample type
//   obuf_state_t : priming FSM state
//   lvl_w()      : width needed to hold an occupancy of 0..depth
package outbuf_pkg;

  localparam int SAMPLE_W = 9;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic {PRIME, RUN} obuf_state_t;

  // Occupancy must represent DEPTH itself, so one bit beyond the pointer width.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/outbuf_mem.sv
// outbuf_mem: DEPTH x W sample storage for the output buffer.
//   clk : write clock
//   we  : write enable
//   wa  : write address (tail)
//   wd  : write data
//   ra  : read address (next head, combinational)
//   rd  : read data, asynchronous
// The array has no reset; occupancy tracking in the parent decides which
// entries are meaningful.
module outbuf_mem
  import outbuf_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = SAMPLE_W
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   wa,
  input  logic signed [W-1:0]        wd,
  input  logic [$clog2(DEPTH)-1:0]   ra,
  output logic signed [W-1:0]        rd
);

  logic signed [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  assign rd = mem[ra];

endmodule

// File: rtl/spline_out_buf.sv
// spline_out_buf: elastic output buffer behind the C-MOMS spline interpolator.
// Drops the first PIPE_FILL strobes after reset (pipeline priming), then
// queues each sample and hands it downstream on a valid/ready handshake.
//   clk      : system clock
//   reset    : asynchronous active-low reset
//   ena_out  : interpolator strobe; y_in carries the new sample one clk later
//   y_in     : interpolator sample (signed)
//   rdy_in   : downstream ready
//   clr_ovf  : synchronous clear of the ovf sticky flag
//   y_out    : head sample, registered, stable while stalled
//   vld_out  : y_out valid
//   level    : FIFO occupancy 0..DEPTH
//   ovf      : sticky, a sample was dropped on full
//   primed   : priming strobes have all been discarded
// Optional feature macro OUTBUF_STATS_EN adds n_out / n_drop saturating
// 16-bit counters of popped and dropped samples.
module spline_out_buf
  import outbuf_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int PIPE_FILL = 4,
  parameter int W         = SAMPLE_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ena_out,
  input  logic signed [W-1:0]      y_in,
  input  logic                     rdy_in,
  input  logic                     clr_ovf,
  output logic signed [W-1:0]      y_out,
  output logic                     vld_out,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  output logic                     primed
`ifdef OUTBUF_STATS_EN
  ,
  output logic [15:0]              n_out,
  output logic [15:0]              n_drop
`endif
);

  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = lvl_w(DEPTH);
  localparam int PCW = (PIPE_FILL > 1) ? $clog2(PIPE_FILL) : 1;
  localparam obuf_state_t RST_ST = (PIPE_FILL == 0) ? RUN : PRIME;

  obuf_state_t         state, state_nxt;
  logic [PCW-1:0]      pcnt, pcnt_nxt;
  logic                wr_stb;
  logic                wr_acc;
  logic [AW-1:0]       wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [LW-1:0]       level_nxt;
  logic                full, pop, wr_en, drop;
  logic signed [W-1:0] mem_rd, head_nxt;

  // The sample belonging to a strobe arrives one clk after it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wr_stb <= 1'b0;
    else        wr_stb <= ena_out;
  end

  // Priming FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RST_ST;
      pcnt  <= '0;
    end else begin
      state <= state_nxt;
      pcnt  <= pcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pcnt_nxt  = pcnt;
    wr_acc    = 1'b0;
    case (state)
      PRIME: begin
        if (wr_stb) begin
          if (pcnt == PCW'(PIPE_FILL - 1)) state_nxt = RUN;
          else                              pcnt_nxt  = pcnt + PCW'(1);
        end
      end
      RUN:     wr_acc = wr_stb;
      default: state_nxt = RST_ST;
    endcase
  end

  assign primed = (state == RUN);

  // FIFO control. level counts stored entries; the head is mirrored in the
  // y_out register, so full/empty come straight from level.
  assign full       = (level == LW'(DEPTH));
  assign pop        = vld_out & rdy_in;
  assign wr_en      = wr_acc & (~full | pop);
  assign drop       = wr_acc & full & ~pop;
  assign rd_ptr_nxt = pop ? rd_ptr + AW'(1) : rd_ptr;
  assign level_nxt  = level + LW'(wr_en) - LW'(pop);

  // When the entry being written is also the next head (FIFO empty after
  // this cycle's pop), forward y_in so vld_out rises with the write.
  assign head_nxt = (wr_en && (wr_ptr == rd_ptr_nxt)) ? y_in : mem_rd;

  outbuf_mem #(.DEPTH(DEPTH), .W(W)) u_mem (
    .clk (clk),
    .we  (wr_en),
    .wa  (wr_ptr),
    .wd  (y_in),
    .ra  (rd_ptr_nxt),
    .rd  (mem_rd)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      vld_out <= 1'b0;
      y_out   <= '0;
      ovf     <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr + AW'(wr_en);
      rd_ptr  <= rd_ptr_nxt;
      level   <= level_nxt;
      vld_out <= (level_nxt != '0);
      if (level_nxt != '0) y_out <= head_nxt;
      // A drop in the same cycle as a clear leaves the flag set.
      if (drop)         ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end

`ifdef OUTBUF_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_out  <= '0;
      n_drop <= '0;
    end else begin
      if (pop  && n_out  != 16'hFFFF) n_out  <= n_out  + 16'd1;
      if (drop && n_drop != 16'hFFFF) n_drop <= n_drop + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spline_out_buf.sv
module tb_spline_out_buf;
  import outbuf_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              ena_out = 1'b0;
  logic signed [8:0] y_in = '0;
  logic              rdy_in = 1'b0;
  logic              clr_ovf = 1'b0;
  logic signed [8:0] y_out;
  logic              vld_out;
  logic [3:0]        level;
  logic              ovf;
  logic              primed;
`ifdef OUTBUF_STATS_EN
  logic [15:0]       n_out, n_drop;
`endif

  spline_out_buf #(.DEPTH(8), .PIPE_FILL(4), .W(9)) dut (
    .clk     (clk),
    .reset   (reset),
    .ena_out (ena_out),
    .y_in    (y_in),
    .rdy_in  (rdy_in),
    .clr_ovf (clr_ovf),
    .y_out   (y_out),
    .vld_out (vld_out),
    .level   (level),
    .ovf     (ovf),
    .primed  (primed)
`ifdef OUTBUF_STATS_EN
    ,
    .n_out   (n_out),
    .n_drop  (n_drop)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit ena;
    int y;
    bit rdy;
    bit exp_vld;
    int exp_y;
    int exp_lvl;
    bit exp_primed;
  } vec_t;

  vec_t vq[$];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Strobe, then present the sample on the following cycle; returns just
  // after the edge that captures it.
  task automatic strobe(input int v);
    ena_out = 1'b1;
    tick();
    ena_out = 1'b0;
    y_in    = 9'(v);
    tick();
  endtask

  task automatic add(input bit e, input int y, input bit r, input bit ev,
                     input int ey, input int el, input bit ep);
    vec_t t;
    t.ena = e; t.y = y; t.rdy = r; t.exp_vld = ev;
    t.exp_y = ey; t.exp_lvl = el; t.exp_primed = ep;
    vq.push_back(t);
  endtask

  initial begin
    int smp[4];
    int base_out;
    smp = '{5, -7, 100, -256};

    // priming: 4 strobes, all discarded, primed after the 4th capture
    add(1, 0, 0, 0, 0, 0, 0);
    add(0, 10, 0, 0, 0, 0, 0);
    add(1, 10, 0, 0, 0, 0, 0);
    add(0, 20, 0, 0, 0, 0, 0);
    add(1, 20, 0, 0, 0, 0, 0);
    add(0, 30, 0, 0, 0, 0, 0);
    add(1, 30, 0, 0, 0, 0, 0);
    add(0, 40, 0, 0, 0, 0, 1);
    // 3-of-12 cadence, consumer always ready
    for (int i = 0; i < 4; i++) begin
      add(1, (i == 0) ? 40 : smp[i-1], 1, 0, 0, 0, 1);
      add(0, smp[i], 1, 1, smp[i], 1, 1);
      add(0, smp[i], 1, 0, 0, 0, 1);
      add(0, smp[i], 1, 0, 0, 0, 1);
    end

    // reset state
    #1;
    chk("rst_vld", vld_out, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_primed", primed, 0);
    chk("rst_y", y_out, 0);
    tick(); tick();
    reset = 1'b1;

    // table
    for (int i = 0; i < vq.size(); i++) begin
      ena_out = vq[i].ena;
      y_in    = 9'(vq[i].y);
      rdy_in  = vq[i].rdy;
      tick();
      chk($sformatf("vec%0d_vld", i), vld_out, vq[i].exp_vld);
      chk($sformatf("vec%0d_level", i), level, vq[i].exp_lvl);
      chk($sformatf("vec%0d_primed", i), primed, vq[i].exp_primed);
      if (vq[i].exp_vld) chk($sformatf("vec%0d_y", i), y_out, vq[i].exp_y);
    end

    // overflow fill: 9 strobes with consumer stalled
    rdy_in = 1'b0;
`ifdef OUTBUF_STATS_EN
    base_out = n_out;
`else
    base_out = 0;
`endif
    for (int k = 1; k <= 9; k++) begin
      strobe(k);
      chk($sformatf("fill%0d_level", k), level, (k > 8) ? 8 : k);
      chk($sformatf("fill%0d_ovf", k), ovf, (k == 9) ? 1 : 0);
    end
    chk("fill_head", y_out, 1);
    rdy_in = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("drain%0d_vld", k), vld_out, 1);
      chk($sformatf("drain%0d_y", k), y_out, k);
      tick();
    end
    rdy_in = 1'b0;
    chk("drain_empty_vld", vld_out, 0);
    chk("drain_empty_level", level, 0);
    chk("ovf_sticky", ovf, 1);
`ifdef OUTBUF_STATS_EN
    chk("n_drop", n_drop, 1);
    chk("n_out", n_out - base_out, 8);
`endif

    // clear with no drop
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("clr_ovf", ovf, 0);

    // full + simultaneous pop and write
    for (int k = 11; k <= 18; k++) strobe(k);
    chk("full2_level", level, 8);
    ena_out = 1'b1;
    tick();
    ena_out = 1'b0;
    y_in    = -9'sd1;
    rdy_in  = 1'b1;
    tick();
    rdy_in  = 1'b0;
    chk("popwr_level", level, 8);
    chk("popwr_ovf", ovf, 0);
    chk("popwr_y", y_out, 12);

    // clear coinciding with a drop: drop wins
    ena_out = 1'b1;
    tick();
    ena_out = 1'b0;
    y_in    = -9'sd99;
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("clrdrop_ovf", ovf, 1);
    tick();
    chk("clrdrop_ovf_hold", ovf, 1);
    chk("clrdrop_level", level, 8);
    rdy_in = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain2_%0d_y", k), y_out, (k == 7) ? -1 : 12 + k);
      tick();
    end
    rdy_in = 1'b0;
    chk("drain2_empty", vld_out, 0);

    // asynchronous reset mid-operation
    for (int k = 21; k <= 25; k++) strobe(k);
    chk("pre_rst_level", level, 5);
    chk("pre_rst_vld", vld_out, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_vld", vld_out, 0);
    chk("midrst_level", level, 0);
    chk("midrst_primed", primed, 0);
    tick();
    reset = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      strobe(30 + k);
      chk($sformatf("reprime%0d_level", k), level, 0);
      chk($sformatf("reprime%0d_primed", k), primed, (k == 4) ? 1 : 0);
    end
    strobe(77);
    chk("post_reprime_vld", vld_out, 1);
    chk("post_reprime_y", y_out, 77);
    chk("post_reprime_level", level, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
